instr_fetch_queue: RTL and testbench

//  Front-end fetch stage feeding instruction_decoder: generates sequential PCs, issues
//  in-order requests to instruction memory and buffers returned words with their PC.

---
 rtl/instr_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch stage: sequential PC generation, in-order imem requests, {pc, instr} buffer to decode.
// Optional macro IFQ_BYPASS_EN adds a zero-latency response-to-decode path when the buffer is empty.
module instr_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] PC_RESET        = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned IW = 2;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned PN = 1 << PW;

    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   pcq       [PN];

    logic [AW-1:0] head, head_n, tail, tail_n;
    logic [CW-1:0] count, count_n;
    logic [IW-1:0] inflight, inflight_n, drop_cnt, drop_n;
    logic [PW-1:0] pcq_rd, pcq_rd_n, pcq_wr, pcq_wr_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic          req_valid_q, req_valid_n;
    logic          out_valid_q, out_valid_n;
    logic [31:0]   out_pc_q, out_pc_n, out_instr_q, out_instr_n;

    logic          fire, pop, push, byp_hit, byp_take;
    logic [31:0]   resp_pc;

    // PC FIFO pointers wrap at MAX_OUTSTANDING, which need not be a power of two
    function automatic logic [PW-1:0] pq_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fire    = req_valid_q & imem_req_ready;
    assign pop     = out_valid_q & out_ready;
    assign resp_pc = pcq[pcq_rd];

`ifdef IFQ_BYPASS_EN
    assign byp_hit = (count == '0) & (drop_cnt == '0) & ~redirect_valid & imem_resp_valid;
`else
    assign byp_hit = 1'b0;
`endif
    assign byp_take = byp_hit & out_ready;
    assign push     = imem_resp_valid & (drop_cnt == '0) & ~redirect_valid & ~byp_take;

    // Next-state for counters, pointers, fetch PC and registered outputs
    always_comb begin
        inflight_n  = inflight + IW'(fire) - IW'(imem_resp_valid);
        pcq_wr_n    = fire ? pq_inc(pcq_wr) : pcq_wr;
        pcq_rd_n    = imem_resp_valid ? pq_inc(pcq_rd) : pcq_rd;
        fetch_pc_n  = fire ? fetch_pc + 32'd4 : fetch_pc;
        tail_n      = tail + AW'(push);
        head_n      = head + AW'(pop);
        count_n     = count + CW'(push) - CW'(pop);
        drop_n      = drop_cnt;
        out_pc_n    = out_pc_q;
        out_instr_n = out_instr_q;

        if (imem_resp_valid && (drop_cnt != '0))
            drop_n = drop_cnt - IW'(1);

        // Redirect discards everything still in flight, including this cycle's request
        if (redirect_valid) begin
            fetch_pc_n = {redirect_pc[31:2], 2'b00};
            head_n     = tail;
            count_n    = '0;
            drop_n     = inflight_n;
        end

        req_valid_n = ((SW'(count_n) + SW'(inflight_n)) < SW'(DEPTH)) &&
                      (inflight_n < IW'(MAX_OUTSTANDING));

        out_valid_n = (count_n != '0);
        if (count_n != '0) begin
            if (push && ((count - CW'(pop)) == '0)) begin
                out_pc_n    = resp_pc;
                out_instr_n = imem_resp_data;
            end else begin
                out_pc_n    = buf_pc[head_n];
                out_instr_n = buf_instr[head_n];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            inflight    <= '0;
            drop_cnt    <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            fetch_pc    <= PC_RESET;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            head        <= head_n;
            tail        <= tail_n;
            count       <= count_n;
            inflight    <= inflight_n;
            drop_cnt    <= drop_n;
            pcq_rd      <= pcq_rd_n;
            pcq_wr      <= pcq_wr_n;
            fetch_pc    <= fetch_pc_n;
            req_valid_q <= req_valid_n;
            out_valid_q <= out_valid_n;
            out_pc_q    <= out_pc_n;
            out_instr_q <= out_instr_n;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[tail]    <= resp_pc;
            buf_instr[tail] <= imem_resp_data;
        end
        if (fire)
            pcq[pcq_wr] <= fetch_pc;
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc;

`ifdef IFQ_BYPASS_EN
    assign out_valid = out_valid_q | byp_hit;
    assign out_pc    = byp_hit ? resp_pc : out_pc_q;
    assign out_instr = byp_hit ? imem_resp_data : out_instr_q;
`else
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && (inflight == '0)));
            assert (!(imem_resp_valid && (drop_cnt == '0) && (count == CW'(DEPTH))));
            assert (inflight <= IW'(MAX_OUTSTANDING));
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: in-order memory model with configurable latency,
// stream check of every decode handoff against the expected sequential PC.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          npop  = 0;
    int          max_pq = 0;
    int          n0;
    bit          req_rand = 0, pop_rand = 0, hold_req = 0, pop_en = 1;
    logic [31:0] exp_pc;
    logic [31:0] pq_addr [$];
    int          pq_due  [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h2402_3001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, sample #1 later, record fires and check pops
    task automatic step(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
        @(negedge clk);
        cyc++;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = hold_req ? 1'b0 : (req_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        out_ready      = pop_rand ? 1'($urandom_range(0, 1)) : pop_en;
        if (pq_addr.size() != 0 && pq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pq_addr.push_back(imem_req_addr);
            pq_due.push_back(cyc + lat);
        end
        if (pq_addr.size() > max_pq) max_pq = pq_addr.size();
        if (out_valid && out_ready) begin
            check("stream_pc", out_pc, exp_pc);
            check("stream_instr", out_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            npop++;
        end
        if (redir) exp_pc = {rpc[31:2], 2'b00};
    endtask

    task automatic wait_out(input int budget, input string tag);
        int n = 0;
        step();
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        exp_pc = 32'h3000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h3000);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // sequential fetch with 1-cycle memory
        step();
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h3000);
        step();
`ifdef IFQ_BYPASS_EN
        check("byp_valid", 32'(out_valid), 32'd1);
        check("byp_instr", out_instr, 32'h2402_0001);
`else
        check("lat_out_valid", 32'(out_valid), 32'd0);
        step();
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_out_pc", out_pc, 32'h3000);
        check("first_out_instr", out_instr, 32'h2402_0001);
`endif
        repeat (20) step();

        // backpressure: buffer fills to DEPTH, requests stop, nothing lost
        pop_en = 1'b0;
        repeat (10) step();
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_head_pc", out_pc, exp_pc);
        hold_req = 1'b1; pop_en = 1'b1; n0 = npop;
        repeat (8) step();
        check("stall_depth", 32'(npop - n0), 32'd4);
        hold_req = 1'b0;
        repeat (10) step();

        // 2-cycle memory, redirect with two requests in flight
        lat = 2;
        repeat (12) step();
        n0 = 0;
        while (pq_addr.size() != 2 && n0 < 20) begin step(); n0++; end
        check("two_inflight", 32'(pq_addr.size()), 32'd2);
        step(1'b1, 32'h0000_3100);
        wait_out(20, "redir1");
        check("redir1_pc", out_pc, 32'h3100);

        // misaligned redirect, address wrap, back-to-back redirects
        lat = 1;
        step(1'b1, 32'h0000_3103);
        wait_out(20, "redir_align");
        check("redir_align_pc", out_pc, 32'h3100);
        step(1'b1, 32'hFFFF_FFFC);
        wait_out(20, "redir_top");
        check("redir_top_pc", out_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_valid", 32'(out_valid), 32'd1);
        check("wrap_pc", out_pc, 32'h0);
        step(1'b1, 32'h0000_5000);
        step(1'b1, 32'h0000_6000);
        wait_out(20, "redir_b2b");
        check("redir_b2b_pc", out_pc, 32'h6000);

        // random request/decode handshakes with occasional redirects
        req_rand = 1'b1; pop_rand = 1'b1; max_pq = 0; n0 = npop;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) lat = 2;
            if ($urandom_range(0, 63) == 0) step(1'b1, $urandom);
            else step();
        end
        req_rand = 1'b0; pop_rand = 1'b0; pop_en = 1'b1; lat = 1;
        check("max_inflight_ok", 32'(max_pq <= 2), 32'd1);
        check("rand_progress", 32'((npop - n0) > 200), 32'd1);
        repeat (10) step();

        // reset with 3 buffered and 1 in flight
        pop_en = 1'b0;
        repeat (10) step();
        pop_en = 1'b1; hold_req = 1'b1;
        step();
        pop_en = 1'b0; hold_req = 1'b0;
        step();
        check("pre_rst_inflight", 32'(pq_addr.size()), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        imem_resp_valid = 1'b0;
        pq_addr.delete();
        pq_due.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("mid_rst_out_pc", out_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h3000;
        pop_en = 1'b1;
        wait_out(10, "restart");
        check("restart_pc", out_pc, 32'h3000);
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
